// File: rtl/axis_dest_demux_if.sv
// AXI Stream channel bundle used by axis_dest_demux for its input and four outputs.
interface axis_dest_demux_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] TDATA;
    logic                  TVALID;
    logic                  TREADY;
    logic                  TLAST;

    modport master (output TDATA, output TVALID, output TLAST, input TREADY);
    modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/axis_dest_demux.sv
// Steers each packet of one AXI Stream to one of four outputs by the 2-bit header field.
// Optional build macro AXIS_DEMUX_STRIP_HEADER_EN consumes header beats instead of forwarding them.
module axis_dest_demux #(
    parameter int DATA_WIDTH = 8,
    parameter int DEST_LSB   = 0
) (
    input  logic               clk,
    input  logic               rst,
    axis_dest_demux_if.slave   src,
    axis_dest_demux_if.master  dst0,
    axis_dest_demux_if.master  dst1,
    axis_dest_demux_if.master  dst2,
    axis_dest_demux_if.master  dst3
);
    typedef enum logic {HEAD, BODY} state_t;

    state_t                state_reg;
    logic [1:0]            dest_reg;
    logic                  occ_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  last_reg;
    logic [1:0]            dest_q_reg;

    logic [3:0]            dst_ready;
    logic [3:0]            dst_valid;
    logic                  sel_ready;
    logic                  src_ready;
    logic                  accept;
    logic                  load;
    logic [1:0]            beat_dest;
    logic [1:0]            hdr_dest;

    assign dst_ready = {dst3.TREADY, dst2.TREADY, dst1.TREADY, dst0.TREADY};
    assign sel_ready = dst_ready[dest_q_reg];
    assign hdr_dest  = src.TDATA[DEST_LSB +: 2];
    assign beat_dest = (state_reg == HEAD) ? hdr_dest : dest_reg;

`ifdef AXIS_DEMUX_STRIP_HEADER_EN
    // Headers never enter the holding register, so they can always be taken.
    assign src_ready = (state_reg == HEAD) ? 1'b1 : (!occ_reg || sel_ready);
    assign accept    = src.TVALID && src_ready;
    assign load      = accept && (state_reg == BODY);
`else
    assign src_ready = !occ_reg || sel_ready;
    assign accept    = src.TVALID && src_ready;
    assign load      = accept;
`endif

    assign src.TREADY = src_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= HEAD;
            dest_reg  <= 2'd0;
        end else if (accept) begin
            if (state_reg == HEAD) begin
                dest_reg  <= hdr_dest;
                state_reg <= src.TLAST ? HEAD : BODY;
            end else if (src.TLAST) begin
                state_reg <= HEAD;
            end
        end
    end

    // dest_q travels with each held beat so a new header can be latched under it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_reg    <= 1'b0;
            data_reg   <= '0;
            last_reg   <= 1'b0;
            dest_q_reg <= 2'd0;
        end else if (load) begin
            occ_reg    <= 1'b1;
            data_reg   <= src.TDATA;
            last_reg   <= src.TLAST;
            dest_q_reg <= beat_dest;
        end else if (occ_reg && sel_ready) begin
            occ_reg    <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_valid
            assign dst_valid[gi] = occ_reg && (dest_q_reg == 2'(gi));
        end
    endgenerate

    assign dst0.TVALID = dst_valid[0];
    assign dst1.TVALID = dst_valid[1];
    assign dst2.TVALID = dst_valid[2];
    assign dst3.TVALID = dst_valid[3];

    assign dst0.TDATA = data_reg;
    assign dst1.TDATA = data_reg;
    assign dst2.TDATA = data_reg;
    assign dst3.TDATA = data_reg;

    assign dst0.TLAST = last_reg;
    assign dst1.TLAST = last_reg;
    assign dst2.TLAST = last_reg;
    assign dst3.TLAST = last_reg;
endmodule

// File: tb/tb_axis_dest_demux.sv
// Directed self-checking bench for axis_dest_demux (DEST_LSB=0 and DEST_LSB=4 instances).
module tb_axis_dest_demux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    axis_dest_demux_if #(.DATA_WIDTH(8)) s_if ();
    axis_dest_demux_if #(.DATA_WIDTH(8)) d0_if ();
    axis_dest_demux_if #(.DATA_WIDTH(8)) d1_if ();
    axis_dest_demux_if #(.DATA_WIDTH(8)) d2_if ();
    axis_dest_demux_if #(.DATA_WIDTH(8)) d3_if ();

    axis_dest_demux_if #(.DATA_WIDTH(8)) s4_if ();
    axis_dest_demux_if #(.DATA_WIDTH(8)) e0_if ();
    axis_dest_demux_if #(.DATA_WIDTH(8)) e1_if ();
    axis_dest_demux_if #(.DATA_WIDTH(8)) e2_if ();
    axis_dest_demux_if #(.DATA_WIDTH(8)) e3_if ();

    axis_dest_demux #(.DATA_WIDTH(8), .DEST_LSB(0)) dut (
        .clk(clk), .rst(rst), .src(s_if),
        .dst0(d0_if), .dst1(d1_if), .dst2(d2_if), .dst3(d3_if)
    );

    axis_dest_demux #(.DATA_WIDTH(8), .DEST_LSB(4)) dut4 (
        .clk(clk), .rst(rst), .src(s4_if),
        .dst0(e0_if), .dst1(e1_if), .dst2(e2_if), .dst3(e3_if)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic [3:0] r);
        s_if.TVALID  = v;
        s_if.TDATA   = d;
        s_if.TLAST   = l;
        d0_if.TREADY = r[0];
        d1_if.TREADY = r[1];
        d2_if.TREADY = r[2];
        d3_if.TREADY = r[3];
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] vld, input logic [7:0] d, input logic l);
        check_val({tag, ".valid"},
                  {28'd0, d3_if.TVALID, d2_if.TVALID, d1_if.TVALID, d0_if.TVALID}, {28'd0, vld});
        if (vld != 4'b0000) begin
            check_val({tag, ".data"}, {24'd0, d0_if.TDATA}, {24'd0, d});
            check_val({tag, ".last"}, {31'd0, d0_if.TLAST}, {31'd0, l});
        end
    endtask

    initial begin
        s4_if.TVALID = 1'b0;
        s4_if.TDATA  = 8'h00;
        s4_if.TLAST  = 1'b0;
        e0_if.TREADY = 1'b1;
        e1_if.TREADY = 1'b1;
        e2_if.TREADY = 1'b1;
        e3_if.TREADY = 1'b1;

        // valid held high during reset must not be accepted
        drive(1'b1, 8'h03, 1'b1, 4'hF);
        tick();
        tick();
        check_val("rst.src_ready", {31'd0, s_if.TREADY}, 32'd1);
        check_val("rst.data", {24'd0, d0_if.TDATA}, 32'd0);
        check_val("rst.last", {31'd0, d0_if.TLAST}, 32'd0);
        expect_out("rst", 4'b0000, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 4'hF);
        rst = 1'b0;
        tick();
        expect_out("post_rst", 4'b0000, 8'h00, 1'b0);

`ifdef AXIS_DEMUX_STRIP_HEADER_EN
        drive(1'b1, 8'h02, 1'b0, 4'hF);
        tick();
        expect_out("strip.hdr", 4'b0000, 8'h00, 1'b0);
        drive(1'b1, 8'h11, 1'b0, 4'hF);
        tick();
        expect_out("strip.b1", 4'b0100, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b1, 4'hF);
        tick();
        expect_out("strip.b2", 4'b0100, 8'h22, 1'b1);
        drive(1'b1, 8'h01, 1'b1, 4'hF);
        check_val("strip.empty.ready", {31'd0, s_if.TREADY}, 32'd1);
        tick();
        expect_out("strip.empty", 4'b0000, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 4'hF);
        check_val("strip.idle.ready", {31'd0, s_if.TREADY}, 32'd1);
        tick();
        expect_out("strip.idle", 4'b0000, 8'h00, 1'b0);
`else
        // 3-beat packet to dst2
        drive(1'b1, 8'h02, 1'b0, 4'hF);
        tick();
        expect_out("p1.b0", 4'b0100, 8'h02, 1'b0);
        drive(1'b1, 8'h11, 1'b0, 4'hF);
        tick();
        expect_out("p1.b1", 4'b0100, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b1, 4'hF);
        tick();
        expect_out("p1.b2", 4'b0100, 8'h22, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 4'hF);
        tick();
        expect_out("p1.drain", 4'b0000, 8'h00, 1'b0);

        // back-to-back packets, destination switch without bubble
        drive(1'b1, 8'h01, 1'b0, 4'hF);
        tick();
        expect_out("p2.b0", 4'b0010, 8'h01, 1'b0);
        drive(1'b1, 8'hAA, 1'b1, 4'hF);
        check_val("p2.ready0", {31'd0, s_if.TREADY}, 32'd1);
        tick();
        expect_out("p2.b1", 4'b0010, 8'hAA, 1'b1);
        drive(1'b1, 8'h03, 1'b1, 4'hF);
        check_val("p2.ready1", {31'd0, s_if.TREADY}, 32'd1);
        tick();
        expect_out("p3.b0", 4'b1000, 8'h03, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 4'hF);
        tick();
        expect_out("p3.drain", 4'b0000, 8'h00, 1'b0);

        // backpressure on dst0 while the other outputs are ready
        drive(1'b1, 8'h00, 1'b0, 4'b1110);
        check_val("bp.ready_empty", {31'd0, s_if.TREADY}, 32'd1);
        tick();
        expect_out("bp.b0", 4'b0001, 8'h00, 1'b0);
        drive(1'b1, 8'h55, 1'b0, 4'b1110);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("bp.stall%0d.ready", i), {31'd0, s_if.TREADY}, 32'd0);
            tick();
            expect_out($sformatf("bp.stall%0d", i), 4'b0001, 8'h00, 1'b0);
        end
        drive(1'b1, 8'h55, 1'b0, 4'hF);
        check_val("bp.release.ready", {31'd0, s_if.TREADY}, 32'd1);
        tick();
        expect_out("bp.b1", 4'b0001, 8'h55, 1'b0);
        drive(1'b1, 8'h66, 1'b1, 4'hF);
        tick();
        expect_out("bp.b2", 4'b0001, 8'h66, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 4'hF);
        tick();
        expect_out("bp.drain", 4'b0000, 8'h00, 1'b0);

        // reset in the middle of a packet
        drive(1'b1, 8'h02, 1'b0, 4'hF);
        tick();
        expect_out("mr.b0", 4'b0100, 8'h02, 1'b0);
        drive(1'b1, 8'h10, 1'b0, 4'hF);
        tick();
        expect_out("mr.b1", 4'b0100, 8'h10, 1'b0);
        rst = 1'b1;
        drive(1'b1, 8'h20, 1'b1, 4'hF);
        expect_out("mr.in_rst", 4'b0000, 8'h00, 1'b0);
        check_val("mr.data_cleared", {24'd0, d0_if.TDATA}, 32'd0);
        tick();
        expect_out("mr.held", 4'b0000, 8'h00, 1'b0);
        rst = 1'b0;
        drive(1'b1, 8'h21, 1'b1, 4'hF);
        tick();
        expect_out("mr.hdr", 4'b0010, 8'h21, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 4'hF);
        tick();
        expect_out("mr.drain", 4'b0000, 8'h00, 1'b0);
`endif

        // destination field at bit 4
        s4_if.TVALID = 1'b1;
        s4_if.TDATA  = 8'h30;
        s4_if.TLAST  = 1'b1;
        tick();
        check_val("lsb4.valid",
                  {28'd0, e3_if.TVALID, e2_if.TVALID, e1_if.TVALID, e0_if.TVALID},
`ifdef AXIS_DEMUX_STRIP_HEADER_EN
                  32'h0);
`else
                  32'h8);
        check_val("lsb4.data", {24'd0, e3_if.TDATA}, 32'h30);
`endif
        s4_if.TVALID = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_dest_demux.md
# axis_dest_demux

- Downstream consumer of the star-arbiter chain output: takes the single merged AXI Stream and steers each packet to one of four output streams.
- Destination is the 2-bit field of the first beat (header) of each packet; the route is held until that packet's TLAST beat.
- One registered output stage gives 1-cycle latency with full throughput.

## Interface
Parameters:
- DATA_WIDTH, 8, width of all TDATA buses
- DEST_LSB, 0, bit position of the 2-bit destination field in the header beat; legal range 0..DATA_WIDTH-2

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- src_TDATA  in  DATA_WIDTH  merged input data
- src_TVALID  in  1  input valid
- src_TREADY  out  1  input ready
- src_TLAST  in  1  input end of packet
- dstN_TDATA  out  DATA_WIDTH  output data, N = 0..3, shared value on all four
- dstN_TVALID  out  1  output valid for destination N
- dstN_TREADY  in  1  output ready for destination N
- dstN_TLAST  out  1  output end of packet, shared value on all four

## Operation
- Input handshake: accept when src_TVALID && src_TREADY. Output handshake on N: dstN_TVALID && dstN_TREADY.
- FSM, 2 states:
  - HEAD: next accepted beat is a header. Latch dest_r = src_TDATA[DEST_LSB+1:DEST_LSB]. Go to BODY unless src_TLAST=1.
  - BODY: accepted beats use dest_r. An accepted beat with TLAST returns to HEAD.
- Holding register: occ, data_q, last_q, dest_q. dest_q is stored per beat, so a new header may be latched while the previous packet's final beat is still held.
- dstN_TVALID = occ && (dest_q == N). dstN_TDATA = data_q and dstN_TLAST = last_q on all N.
- sel_ready = dstN_TREADY for N = dest_q.
- src_TREADY = !occ || sel_ready. It is combinational from the selected TREADY, with no dependency on src_TVALID.
- Header beats are forwarded (default build). Single-beat packet (header with TLAST): routed, state stays HEAD.
- Non-selected dstN_TREADY values are ignored and have no effect on any state.

## Timing
- Reset values: occ=0, all dstN_TVALID=0, dstN_TDATA=0, dstN_TLAST=0, state=HEAD, dest_r=0. src_TREADY=1 while rst=1.
- Latency: a beat accepted at edge k is visible on its dstN at the output from edge k to edge k+1.
- Throughput: 1 beat/cycle when the selected output holds TREADY high.
- Simultaneous drain and accept in one cycle: register reloads and occ stays 1. No bubble.
- Full (occ && !sel_ready): src_TREADY=0. data_q, last_q and dest_q stay stable and dstN_TVALID stays high (AXI rule: no withdrawal).
- Empty with no input: occ falls at the drain edge.
- Destination switch between back-to-back packets to different outputs: no bubble.
- Reset mid-packet: the held beat is discarded and the FSM returns to HEAD. The first beat accepted after reset is treated as a header.
- src_TVALID may assert during reset; nothing is accepted until rst=0.

## Configuration
- AXIS_DEMUX_STRIP_HEADER_EN
  - Undefined: header beats are forwarded as described above.
  - Defined: header beats are consumed and not forwarded.
    - In HEAD, src_TREADY=1 regardless of occ. The header is accepted, dest_r is latched and the holding register is not touched.
    - A header with TLAST=1 (empty packet) is dropped entirely and the FSM stays in HEAD.
    - In BODY, src_TREADY follows the normal rule.
    - Latency of body beats is unchanged.

## Test plan
- Reset, then 3-beat packet 0x02,0x11,0x22 (TLAST on 0x22) with all TREADY=1 -> dst2 emits 0x02,0x11,0x22 on consecutive cycles, TLAST only on 0x22. dst0, dst1 and dst3 TVALID never assert.
- Back-to-back packets 0x01,0xAA(L) then 0x03(L) with no gaps -> dst1 gets 0x01,0xAA, then dst3 gets 0x03 on the next cycle. No bubble, src_TREADY stays 1.
- Packet to dst0 with dst0_TREADY=0 for 5 cycles and dst1..3_TREADY=1 -> src_TREADY=0 after the first accept. dst0_TDATA/TLAST stable, TVALID held. Stream resumes with no loss or duplicate once TREADY=1.
- Assert rst for 1 cycle in the middle of packet 0x02,0x10,0x20(L), right after 0x10 is accepted -> all TVALID=0 immediately. The next beat 0x21 is treated as a header and routes to dst1.
- DEST_LSB=4, header 0x30 -> routed to dst3.
- With AXIS_DEMUX_STRIP_HEADER_EN: 0x02,0x11,0x22(L) -> dst2 emits only 0x11,0x22(L). Packet 0x01(L) alone -> no output on any dstN, src_TREADY=1 throughout.
